// File: rtl/timer_regs_pkg.sv
// Register map, control-word layout and FSM state type shared by the
// timer_0 host master.
//
// Contents:
//   ADR_*     word addresses of the timer_0 slave registers
//   CTL_*     bit positions inside the control register
//   state_e   host master sequencer states
//   ctl_word  builds a 16-bit control register write value
package timer_regs_pkg;

  localparam logic [2:0] ADR_STATUS  = 3'd0;
  localparam logic [2:0] ADR_CONTROL = 3'd1;
  localparam logic [2:0] ADR_PERIODL = 3'd2;
  localparam logic [2:0] ADR_PERIODH = 3'd3;
  localparam logic [2:0] ADR_SNAPL   = 3'd4;
  localparam logic [2:0] ADR_SNAPH   = 3'd5;

  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  // Program sequence (WrPl/WrPh/WrCtl), stop (WrStop), snapshot (Sn*) and
  // interrupt service (St*).
  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtl,
    StWrStop,
    StSnWr,
    StSnRl,
    StSnRh,
    StSnCap,
    StStRd,
    StStCap,
    StStClr
  } state_e;

  function automatic logic [15:0] ctl_word(input logic stop, input logic start,
                                           input logic cont, input logic ito);
    logic [15:0] w;
    w            = '0;
    w[CTL_STOP]  = stop;
    w[CTL_START] = start;
    w[CTL_CONT]  = cont;
    w[CTL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_0_host_master.sv
// Avalon-MM initiator that programs and services a timer_0 interval timer.
//
// Turns single-cycle local commands into register write/read sequences on
// the timer slave and, when enabled, acknowledges timer interrupts by
// reading then clearing the status register.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cmd_start/stop/snap   command pulses, accepted only while cmd_ready
//   cmd_period            period loaded by a start
//   cmd_cont, cmd_ito     control bits sampled with start or stop
//   cmd_ready             high while idle
//   snap_value/valid      last counter snapshot and its update strobe
//   timeout_pulse         strobe during the status-clear write of a service
//   status_run            RUN bit read during the last service
//   av_*                  Avalon-MM initiator towards timer_0 s1
module timer_0_host_master
  import timer_regs_pkg::*;
#(
  parameter bit AUTO_IRQ_SVC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  input  logic [31:0] cmd_period,
  input  logic        cmd_cont,
  input  logic        cmd_ito,
  output logic        cmd_ready,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic        timeout_pulse,
  output logic        status_run,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_irq
);

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        cont_q, cont_d;
  logic        ito_q, ito_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic        timeout_q, timeout_d;
  logic        status_run_q, status_run_d;
  logic        ready_q, ready_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  // Set for the first idle cycle after a service so a still-asserted irq
  // (slave not yet deasserted) cannot immediately trigger a second service.
  logic        svc_done_q, svc_done_d;

  logic idle;
  logic take_start;
  logic take_ctl;

  assign idle       = (state_q == StIdle);
  assign take_start = idle && cmd_start && !cmd_stop;
  assign take_ctl   = idle && (cmd_start || cmd_stop);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      period_q     <= '0;
      cont_q       <= 1'b0;
      ito_q        <= 1'b0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      status_run_q <= 1'b0;
      ready_q      <= 1'b1;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      svc_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      ito_q        <= ito_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      timeout_q    <= timeout_d;
      status_run_q <= status_run_d;
      ready_q      <= ready_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      svc_done_q   <= svc_done_d;
    end
  end

  // Next-state logic; in idle, stop > start > snap > irq service.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_stop) begin
          state_d = StWrStop;
        end else if (cmd_start) begin
          state_d = StWrPl;
        end else if (cmd_snap) begin
          state_d = StSnWr;
        end else if (AUTO_IRQ_SVC && av_irq && !svc_done_q) begin
          state_d = StStRd;
        end
      end
      StWrPl:   state_d = StWrPh;
      StWrPh:   state_d = StWrCtl;
      StWrCtl:  state_d = StIdle;
      StWrStop: state_d = StIdle;
      StSnWr:   state_d = StSnRl;
      StSnRl:   state_d = StSnRh;
      StSnRh:   state_d = StSnCap;
      StSnCap:  state_d = StIdle;
      StStRd:   state_d = StStCap;
      StStCap:  state_d = StStClr;
      StStClr:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic. Bus outputs are registered, so they are decoded from the
  // state being entered; read data is captured one cycle after each read.
  always_comb begin
    period_d     = take_start ? cmd_period : period_q;
    cont_d       = take_ctl ? cmd_cont : cont_q;
    ito_d        = take_ctl ? cmd_ito : ito_q;
    snap_lo_d    = (state_q == StSnRh) ? av_readdata : snap_lo_q;
    snap_value_d = (state_q == StSnCap) ? {av_readdata, snap_lo_q} : snap_value_q;
    snap_valid_d = (state_q == StSnCap);
    status_run_d = (state_q == StStCap) ? av_readdata[1] : status_run_q;
    svc_done_d   = (state_q == StStClr);
    timeout_d    = 1'b0;
    ready_d      = 1'b0;
    cs_d         = 1'b0;
    wn_d         = 1'b1;
    addr_d       = '0;
    wdata_d      = '0;
    unique case (state_d)
      StIdle: ready_d = 1'b1;
      StWrPl: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADR_PERIODL;
        wdata_d = period_d[15:0];
      end
      StWrPh: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADR_PERIODH;
        wdata_d = period_d[31:16];
      end
      StWrCtl: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADR_CONTROL;
        wdata_d = ctl_word(1'b0, 1'b1, cont_d, ito_d);
      end
      StWrStop: begin
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADR_CONTROL;
        wdata_d = ctl_word(1'b1, 1'b0, cont_d, ito_d);
      end
      StSnWr: begin
        // Any write to SNAPL latches the counter into the snapshot regs.
        cs_d    = 1'b1;
        wn_d    = 1'b0;
        addr_d  = ADR_SNAPL;
      end
      StSnRl: begin
        cs_d    = 1'b1;
        addr_d  = ADR_SNAPL;
      end
      StSnRh: begin
        cs_d    = 1'b1;
        addr_d  = ADR_SNAPH;
      end
      StSnCap: ;
      StStRd: begin
        cs_d    = 1'b1;
        addr_d  = ADR_STATUS;
      end
      StStCap: ;
      StStClr: begin
        cs_d      = 1'b1;
        wn_d      = 1'b0;
        addr_d    = ADR_STATUS;
        timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready     = ready_q;
  assign snap_value    = snap_value_q;
  assign snap_valid    = snap_valid_q;
  assign timeout_pulse = timeout_q;
  assign status_run    = status_run_q;
  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_0_host_master.sv
// Bench for timer_0_host_master with a behavioural timer_0 responder, a
// transaction-level expectation model checked every cycle, and directed
// literal checks.
module tb_timer_0_host_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_snap, cmd_cont, cmd_ito;
  logic [31:0] cmd_period;
  logic        cmd_ready, snap_valid, timeout_pulse, status_run;
  logic [31:0] snap_value;
  logic [2:0]  av_address;
  logic        av_chipselect, av_write_n, av_irq;
  logic [15:0] av_writedata, av_readdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  timer_0_host_master #(.AUTO_IRQ_SVC(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_snap     (cmd_snap),
    .cmd_period   (cmd_period),
    .cmd_cont     (cmd_cont),
    .cmd_ito      (cmd_ito),
    .cmd_ready    (cmd_ready),
    .snap_value   (snap_value),
    .snap_valid   (snap_valid),
    .timeout_pulse(timeout_pulse),
    .status_run   (status_run),
    .av_address   (av_address),
    .av_chipselect(av_chipselect),
    .av_write_n   (av_write_n),
    .av_writedata (av_writedata),
    .av_readdata  (av_readdata),
    .av_irq       (av_irq)
  );

  // ---------------- timer_0 responder ----------------
  logic [31:0] slv_cnt, slv_period, slv_snap;
  logic        slv_run, slv_to, slv_cont, slv_ito;

  assign av_irq = slv_to & slv_ito;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slv_cnt <= '0; slv_period <= '0; slv_snap <= '0;
      slv_run <= 1'b0; slv_to <= 1'b0; slv_cont <= 1'b0; slv_ito <= 1'b0;
      av_readdata <= '0;
    end else begin
      if (av_chipselect && av_write_n) begin
        case (av_address)
          3'd0:    av_readdata <= {14'b0, slv_run, slv_to};
          3'd1:    av_readdata <= {14'b0, slv_cont, slv_ito};
          3'd2:    av_readdata <= slv_period[15:0];
          3'd3:    av_readdata <= slv_period[31:16];
          3'd4:    av_readdata <= slv_snap[15:0];
          3'd5:    av_readdata <= slv_snap[31:16];
          default: av_readdata <= '0;
        endcase
      end else begin
        av_readdata <= '0;
      end
      if (slv_run) begin
        if (slv_cnt == 32'd0) begin
          slv_to  <= 1'b1;
          slv_cnt <= slv_period;
          if (!slv_cont) slv_run <= 1'b0;
        end else begin
          slv_cnt <= slv_cnt - 32'd1;
        end
      end
      if (av_chipselect && !av_write_n) begin
        case (av_address)
          3'd0: slv_to <= 1'b0;
          3'd1: begin
            slv_ito  <= av_writedata[0];
            slv_cont <= av_writedata[1];
            if (av_writedata[2]) begin
              slv_run <= 1'b1;
              slv_cnt <= slv_period;
            end
            if (av_writedata[3]) slv_run <= 1'b0;
          end
          3'd2: slv_period[15:0]  <= av_writedata;
          3'd3: slv_period[31:16] <= av_writedata;
          3'd4: slv_snap <= slv_cnt;
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] bw(input logic cs, input logic wn, input logic [2:0] a,
                                     input logic [15:0] d);
    return {11'b0, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] bus_now();
    return {11'b0, av_chipselect, av_write_n, av_address, av_writedata};
  endfunction

  // ---------------- expectation model ----------------
  // One entry per future clock cycle describing what the master must show.
  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        ready;
    logic        sv;
    logic        tp;
    logic        rec_snap;
    logic        apply_snap;
    logic        rec_run;
    logic        apply_run;
    logic        no_irq;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_snap = '0;
  logic [31:0] snap_pending = '0;
  logic        exp_run = 1'b0;
  logic        run_pending = 1'b0;

  function automatic exp_t mk(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [15:0] d, input logic rdy);
    exp_t e;
    e.cs = cs; e.wn = wn; e.addr = a; e.wdata = d; e.ready = rdy;
    e.sv = 1'b0; e.tp = 1'b0; e.rec_snap = 1'b0; e.apply_snap = 1'b0;
    e.rec_run = 1'b0; e.apply_run = 1'b0; e.no_irq = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin : model
    exp_t cur;
    exp_t e;
    if (reset) begin
      q.delete();
      exp_snap = '0;
      exp_run  = 1'b0;
      cur = mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b1);
    end else begin
      if (q.size() != 0) cur = q.pop_front();
      else cur = mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b1);
      // Slave takes the snapshot / status at the edge ending this cycle.
      if (cur.rec_snap) snap_pending = slv_cnt;
      if (cur.rec_run) run_pending = slv_run;
      if (cur.apply_snap) exp_snap = snap_pending;
      if (cur.apply_run) exp_run = run_pending;
    end
    chk("m_bus", bus_now(), bw(cur.cs, cur.wn, cur.addr, cur.wdata));
    chk("m_cmd_ready", 32'(cmd_ready), 32'(cur.ready));
    chk("m_snap_valid", 32'(snap_valid), 32'(cur.sv));
    chk("m_snap_value", snap_value, exp_snap);
    chk("m_timeout_pulse", 32'(timeout_pulse), 32'(cur.tp));
    chk("m_status_run", 32'(status_run), 32'(exp_run));
    if (!reset && cur.ready) begin
      if (cmd_stop) begin
        q.push_back(mk(1'b1, 1'b0, 3'd1, {12'b0, 2'b10, cmd_cont, cmd_ito}, 1'b0));
      end else if (cmd_start) begin
        q.push_back(mk(1'b1, 1'b0, 3'd2, cmd_period[15:0], 1'b0));
        q.push_back(mk(1'b1, 1'b0, 3'd3, cmd_period[31:16], 1'b0));
        q.push_back(mk(1'b1, 1'b0, 3'd1, {12'b0, 2'b01, cmd_cont, cmd_ito}, 1'b0));
      end else if (cmd_snap) begin
        e = mk(1'b1, 1'b0, 3'd4, 16'h0, 1'b0); e.rec_snap = 1'b1; q.push_back(e);
        q.push_back(mk(1'b1, 1'b1, 3'd4, 16'h0, 1'b0));
        q.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0, 1'b0));
        q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b0));
        e = mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b1); e.sv = 1'b1; e.apply_snap = 1'b1;
        q.push_back(e);
      end else if (av_irq && !cur.no_irq) begin
        e = mk(1'b1, 1'b1, 3'd0, 16'h0, 1'b0); e.rec_run = 1'b1; q.push_back(e);
        q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b0));
        e = mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b0); e.tp = 1'b1; e.apply_run = 1'b1;
        q.push_back(e);
        e = mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b1); e.no_irq = 1'b1; q.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic sp, input logic sn, input logic [31:0] per,
                       input logic cont, input logic ito);
    cmd_start = st; cmd_stop = sp; cmd_snap = sn;
    cmd_period = per; cmd_cont = cont; cmd_ito = ito;
    tick();
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
    cmd_period = 32'hDEAD_BEEF; cmd_cont = ~cont; cmd_ito = ~ito;
  endtask

  task automatic wait_pulse(input int unsigned limit, output int unsigned n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      tick();
      n++;
      if (timeout_pulse) seen = 1'b1;
    end
  endtask

  int unsigned n_cyc;
  bit          seen;

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
    cmd_period = '0; cmd_cont = 1'b0; cmd_ito = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_bus", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0));
    chk("rst_snap_value", snap_value, 32'h0);
    tick();

    // 1: program and start
    issue(1'b1, 1'b0, 1'b0, 32'h0001_0004, 1'b1, 1'b1);
    chk("t1_wr_pl", bus_now(), bw(1'b1, 1'b0, 3'd2, 16'h0004));
    chk("t1_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("t1_wr_ph", bus_now(), bw(1'b1, 1'b0, 3'd3, 16'h0001));
    tick();
    chk("t1_wr_ctl", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0007));
    chk("t1_ready_low3", 32'(cmd_ready), 32'd0);
    tick();
    chk("t1_ready_back", 32'(cmd_ready), 32'd1);
    chk("t1_bus_idle", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0));

    // 2: irq service; counter loaded at the control write, irq after P+1 edges
    wait_pulse(32'h0001_0040, n_cyc, seen);
    chk("t2_seen", 32'(seen), 32'd1);
    chk("t2_latency", n_cyc, 32'h0001_0008);
    chk("t2_clr_write", bus_now(), bw(1'b1, 1'b0, 3'd0, 16'h0000));
    chk("t2_status_run", 32'(status_run), 32'd1);
    tick();
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b1);
    wait_pulse(32'h400, n_cyc, seen);
    chk("t2b_seen", 32'(seen), 32'd1);
    wait_pulse(32'h400, n_cyc, seen);
    chk("t2b_interval", n_cyc, 32'h101);
    tick();
    issue(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_stop", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    tick();

    // 3: snapshot while running
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0);
    repeat (53) tick();
    issue(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    chk("t3_sn_wr", bus_now(), bw(1'b1, 1'b0, 3'd4, 16'h0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_snap_valid", 32'(snap_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("t3_snap_value", snap_value, 32'h0000_00CD);
    chk("t3_snap_le_period", 32'(snap_value <= 32'h100), 32'd1);
    tick();
    chk("t3_valid_pulse", 32'(snap_valid), 32'd0);

    // 4: stop and start together; stop wins
    issue(1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    chk("t4_stop_only", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    tick();
    chk("t4_no_period", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0));
    chk("t4_ready", 32'(cmd_ready), 32'd1);

    // 5: start during SN_RL is ignored
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0);
    repeat (12) tick();
    issue(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    chk("t5_sn_rl", bus_now(), bw(1'b1, 1'b1, 3'd4, 16'h0));
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0055, 1'b0, 1'b0);
    chk("t5_sn_rh", bus_now(), bw(1'b1, 1'b1, 3'd5, 16'h0));
    tick();
    tick();
    chk("t5_snap_valid", 32'(snap_valid), 32'd1);
    tick();
    chk("t5_no_extra", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0));

    // 6: reset in WR_PH
    issue(1'b1, 1'b0, 1'b0, 32'h0002_0003, 1'b0, 1'b0);
    tick();
    chk("t6_in_wr_ph", bus_now(), bw(1'b1, 1'b0, 3'd3, 16'h0002));
    reset = 1'b1;
    #1;
    chk("t6_bus_idle", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0));
    tick();
    reset = 1'b0;
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    chk("t6_snap_clear", snap_value, 32'h0);
    tick();
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0);
    chk("t6_wr_pl", bus_now(), bw(1'b1, 1'b0, 3'd2, 16'h0010));
    tick();
    chk("t6_wr_ph", bus_now(), bw(1'b1, 1'b0, 3'd3, 16'h0000));
    tick();
    chk("t6_wr_ctl", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0006));
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
